// File: rtl/usart_frame_arbiter.sv
// Round-robin arbiter that shares one UART byte sender among four channels.
// Each granted channel emits a fixed 5-byte frame with constant strobe spacing.
module usart_frame_arbiter #(
  parameter logic [15:0] BYTE_GAP = 16'd8680
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [95:0] d_flat,
  input  logic [23:0] mod_sel_flat,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_en,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_DONE
  } state_t;

  // STROBE and SETUP take one cycle each out of every BYTE_GAP
  localparam logic [15:0] GAP_LOAD = BYTE_GAP - 16'd3;

  state_t state;
  state_t state_nxt;

  logic [3:0]       req_d;
  logic [3:0]       pending;
  logic [3:0]       pend_set;
  logic [3:0]       pend_clr;
  logic [1:0]       rr;
  logic [1:0]       sel;
  logic [1:0]       arb_sel;
  logic             arb_hit;
  logic [15:0]      gap_cnt;
  logic             gap_end;
  logic [2:0]       k;
  logic [1:0]       nidx;
  logic [3:0][7:0]  frame_buf;
  logic [23:0]      d_ch   [4];
  logic [5:0]       mod_ch [4];

  for (genvar i = 0; i < 4; i++) begin : g_unflat
    assign d_ch[i]   = d_flat[24*i +: 24];
    assign mod_ch[i] = mod_sel_flat[6*i +: 6];
  end

  assign pend_set = req & ~req_d;
  assign pend_clr = (state == S_LOAD) ? (4'b0001 << sel) : 4'b0000;
  assign gap_end  = (gap_cnt == 16'd0);
  assign nidx     = k[1:0] - 2'd1;

  // Search rr+1 .. rr+4; iterating backwards lets the nearest hit win
  always_comb begin
    logic [1:0] idx;
    arb_hit = 1'b0;
    arb_sel = rr;
    idx     = rr;
    for (int o = 4; o >= 1; o--) begin
      idx = rr + 2'(o);
      if (pending[idx]) begin
        arb_hit = 1'b1;
        arb_sel = idx;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (arb_hit) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_STROBE;
      S_STROBE: state_nxt = S_GAP;
      S_GAP: begin
        if (gap_end) begin
          state_nxt = (k < 3'd5) ? S_SETUP : S_DONE;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant      = 4'b0000;
    tx_byte_en = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_LOAD:   grant      = 4'b0001 << sel;
      S_STROBE: tx_byte_en = 1'b1;
      S_DONE:   frame_done = 1'b1;
      default:  ;
    endcase
  end

  // A rise coinciding with the channel's own LOAD still queues a frame
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      req_d   <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      req_d   <= req;
      pending <= (pending & ~pend_clr) | pend_set;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rr  <= 2'd3;
      sel <= 2'd0;
    end else if (state == S_IDLE && arb_hit) begin
      rr  <= arb_sel;
      sel <= arb_sel;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      gap_cnt <= 16'd0;
    end else if (state == S_STROBE) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == S_GAP && !gap_end) begin
      gap_cnt <= gap_cnt - 16'd1;
    end
  end

  // tx_byte changes only on entry to SETUP, so it is valid during SETUP
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_byte   <= 8'h00;
      frame_buf <= '0;
      k         <= 3'd0;
    end else if (state == S_LOAD) begin
      tx_byte      <= {6'd0, sel};
      frame_buf[0] <= {2'b00, mod_ch[sel]};
      frame_buf[1] <= d_ch[sel][23:16];
      frame_buf[2] <= d_ch[sel][15:8];
      frame_buf[3] <= d_ch[sel][7:0];
      k            <= 3'd1;
    end else if (state == S_GAP && gap_end && k < 3'd5) begin
      tx_byte <= frame_buf[nidx];
      k       <= k + 3'd1;
    end
  end

endmodule

// File: tb/tb_usart_frame_arbiter.sv
// Scoreboard bench for usart_frame_arbiter with BYTE_GAP=8.
// Expected strobes are queued at stimulus time and popped on each tx_byte_en.
module tb_usart_frame_arbiter;

  localparam logic [15:0] G  = 16'd8;
  localparam int          GI = 8;
  localparam int          FL = 5 * GI + 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [95:0] d_flat = '0;
  logic [23:0] mod_sel_flat = '0;
  logic [7:0]  tx_byte;
  logic        tx_byte_en;
  logic [3:0]  grant;
  logic        busy;
  logic        frame_done;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int         c;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];

  usart_frame_arbiter #(.BYTE_GAP(G)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req         (req),
    .d_flat      (d_flat),
    .mod_sel_flat(mod_sel_flat),
    .tx_byte     (tx_byte),
    .tx_byte_en  (tx_byte_en),
    .grant       (grant),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [23:0] d, input logic [5:0] m);
    d_flat[24*i +: 24]      = d;
    mod_sel_flat[6*i +: 6]  = m;
  endtask

  task automatic push_frame(input int ch, input int g0);
    exp_t       e;
    logic [23:0] d;
    logic [5:0]  m;
    d = d_flat[24*ch +: 24];
    m = mod_sel_flat[6*ch +: 6];
    e.c = g0 + 2;          e.b = 8'(ch);         sb.push_back(e);
    e.c = g0 + 2 + GI;     e.b = {2'b00, m};     sb.push_back(e);
    e.c = g0 + 2 + 2*GI;   e.b = d[23:16];       sb.push_back(e);
    e.c = g0 + 2 + 3*GI;   e.b = d[15:8];        sb.push_back(e);
    e.c = g0 + 2 + 4*GI;   e.b = d[7:0];         sb.push_back(e);
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({tx_byte, tx_byte_en, grant, busy, frame_done} !== 15'd0) begin
      $display("FAIL reset_hold: got %h expected 0",
               {tx_byte, tx_byte_en, grant, busy, frame_done});
    end else passed++;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick();
    @(negedge sys_clk);
    total++;
    if ({tx_byte, tx_byte_en, grant, busy, frame_done} !== 15'd0) begin
      $display("FAIL reset_release: got %h expected 0",
               {tx_byte, tx_byte_en, grant, busy, frame_done});
    end else passed++;
  endtask

  task automatic test_all_four();
    exp_t e;
    int   c0, rel, f;
    logic [3:0] expg;
    set_ch(0, 24'h102030, 6'h01);
    set_ch(1, 24'h415161, 6'h12);
    set_ch(2, 24'h728292, 6'h23);
    set_ch(3, 24'hA3B3C3, 6'h34);
    tick();
    req = 4'hF;
    c0  = cyc;
    for (int i = 0; i < 4; i++) push_frame(i, c0 + 2 + FL*i);
    for (int r = 0; r < 2 + 4*FL + 2; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 1) req = 4'h0;
      expg = 4'b0000;
      if (rel >= 2 && (rel - 2) % FL == 0) begin
        f = (rel - 2) / FL;
        if (f < 4) expg = 4'b0001 << f;
      end
      if (grant !== 4'b0000 || expg !== 4'b0000) begin
        total++;
        if (grant !== expg) begin
          $display("FAIL all4_grant @%0d: got %b expected %b", rel, grant, expg);
        end else passed++;
      end
      if (tx_byte_en) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL all4_strobe: got unexpected strobe @%0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if (tx_byte !== e.b || cyc !== e.c) begin
            $display("FAIL all4_strobe: got %h@%0d expected %h@%0d", tx_byte, cyc, e.b, e.c);
          end else passed++;
        end
      end
    end
    total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      $display("FAIL all4_end: got left=%0d busy=%b expected 0/0", sb.size(), busy);
    end else passed++;
    sb.delete();
  endtask

  task automatic test_rr_wrap();
    exp_t e;
    int   c0, rel;
    logic [3:0] expg;
    tick();
    req = 4'b1001;
    c0  = cyc;
    push_frame(0, c0 + 2);
    push_frame(3, c0 + 2 + FL);
    for (int r = 0; r < 2 + 2*FL + 2; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 1) req = 4'h0;
      expg = (rel == 2) ? 4'b0001 : (rel == 2 + FL) ? 4'b1000 : 4'b0000;
      if (grant !== 4'b0000 || expg !== 4'b0000) begin
        total++;
        if (grant !== expg) begin
          $display("FAIL rr_grant @%0d: got %b expected %b", rel, grant, expg);
        end else passed++;
      end
      if (tx_byte_en) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL rr_strobe: got unexpected strobe @%0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if (tx_byte !== e.b || cyc !== e.c) begin
            $display("FAIL rr_strobe: got %h@%0d expected %h@%0d", tx_byte, cyc, e.b, e.c);
          end else passed++;
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL rr_end: got left=%0d expected 0", sb.size());
    end else passed++;
    sb.delete();
  endtask

  task automatic test_single();
    exp_t e;
    int   c0, rel, ns;
    set_ch(2, 24'hA5B6C7, 6'h15);
    tick();
    req = 4'b0100;
    c0  = cyc;
    ns  = 0;
    push_frame(2, c0 + 2);
    for (int r = 0; r < 48; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 1) req = 4'h0;
      total++;
      if (busy !== (rel >= 2 && rel <= 43)) begin
        $display("FAIL single_busy @%0d: got %b expected %b", rel, busy, (rel >= 2 && rel <= 43));
      end else passed++;
      if (grant !== 4'b0000 || rel == 2) begin
        total++;
        if (grant !== ((rel == 2) ? 4'b0100 : 4'b0000)) begin
          $display("FAIL single_grant @%0d: got %b expected %b", rel, grant,
                   (rel == 2) ? 4'b0100 : 4'b0000);
        end else passed++;
      end
      if (frame_done || rel == 43) begin
        total++;
        if (frame_done !== (rel == 43)) begin
          $display("FAIL single_done @%0d: got %b expected %b", rel, frame_done, (rel == 43));
        end else passed++;
      end
      if (tx_byte_en) begin
        ns++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL single_strobe: got unexpected strobe @%0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if (tx_byte !== e.b || cyc !== e.c) begin
            $display("FAIL single_strobe: got %h@%0d expected %h@%0d", tx_byte, cyc, e.b, e.c);
          end else passed++;
        end
      end
    end
    total++;
    if (ns != 5 || sb.size() != 0) begin
      $display("FAIL single_count: got %0d strobes expected 5", ns);
    end else passed++;
    sb.delete();
  endtask

  task automatic test_hold_requeue();
    int c0, rel, ng, g2;
    tick();
    req = 4'b0010;
    c0  = cyc;
    ng  = 0;
    for (int r = 0; r < 140; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 100) req = 4'h0;
      if (grant !== 4'b0000) ng++;
    end
    total++;
    if (ng != 1) begin
      $display("FAIL hold_once: got %0d grants expected 1", ng);
    end else passed++;
    tick();
    req = 4'b0010;
    c0  = cyc;
    ng  = 0;
    g2  = -1;
    for (int r = 0; r < 2 + 2*FL + 4; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 10) req = 4'h0;
      if (rel == 11) req = 4'b0010;
      if (grant !== 4'b0000) begin
        ng++;
        total++;
        if (grant !== 4'b0010) begin
          $display("FAIL requeue_grant: got %b expected 0010", grant);
        end else passed++;
        if (ng == 2) g2 = rel;
      end
    end
    req = 4'h0;
    total++;
    if (ng != 2 || g2 != 2 + FL) begin
      $display("FAIL requeue: got %0d grants, 2nd @%0d expected 2, @%0d", ng, g2, 2 + FL);
    end else passed++;
  endtask

  task automatic test_data_change();
    exp_t e;
    int   c0, rel;
    set_ch(0, 24'h123456, 6'h2A);
    tick();
    req = 4'b0001;
    c0  = cyc;
    push_frame(0, c0 + 2);
    for (int r = 0; r < 46; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 1) req = 4'h0;
      if (rel == 3) set_ch(0, 24'h000000, 6'h00);
      if (tx_byte_en) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL hold_data: got unexpected strobe @%0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if (tx_byte !== e.b || cyc !== e.c) begin
            $display("FAIL hold_data: got %h@%0d expected %h@%0d", tx_byte, cyc, e.b, e.c);
          end else passed++;
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL hold_data_end: got left=%0d expected 0", sb.size());
    end else passed++;
    sb.delete();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   c0, rel, ns;
    set_ch(1, 24'hDEADBE, 6'h3F);
    tick();
    req = 4'b0010;
    c0  = cyc;
    push_frame(1, c0 + 2);
    for (int r = 0; r < 16; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 1) req = 4'h0;
      if (tx_byte_en) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL abort_strobe: got unexpected strobe @%0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if (tx_byte !== e.b || cyc !== e.c) begin
            $display("FAIL abort_strobe: got %h@%0d expected %h@%0d", tx_byte, cyc, e.b, e.c);
          end else passed++;
        end
      end
    end
    sys_rst = 1'b0;
    #1;
    total++;
    if ({tx_byte, tx_byte_en, grant, busy, frame_done} !== 15'd0 || sb.size() != 3) begin
      $display("FAIL abort_outputs: got %h left=%0d expected 0 left=3",
               {tx_byte, tx_byte_en, grant, busy, frame_done}, sb.size());
    end else passed++;
    sb.delete();
    ns = 0;
    for (int r = 0; r < 40; r++) begin
      @(negedge sys_clk);
      if (r == 3) sys_rst = 1'b1;
      if (tx_byte_en) ns++;
    end
    total++;
    if (ns != 0 || busy !== 1'b0) begin
      $display("FAIL abort_quiet: got %0d strobes busy=%b expected 0/0", ns, busy);
    end else passed++;
    set_ch(0, 24'h0F1E2D, 6'h03);
    tick();
    req = 4'b0001;
    c0  = cyc;
    push_frame(0, c0 + 2);
    for (int r = 0; r < 48; r++) begin
      @(negedge sys_clk);
      rel = cyc - c0;
      if (rel == 1) req = 4'h0;
      if (tx_byte_en) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL post_reset_strobe: got unexpected strobe @%0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          if (tx_byte !== e.b || cyc !== e.c) begin
            $display("FAIL post_reset_strobe: got %h@%0d expected %h@%0d", tx_byte, cyc, e.b, e.c);
          end else passed++;
        end
      end
    end
    total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      $display("FAIL post_reset_end: got left=%0d busy=%b expected 0/0", sb.size(), busy);
    end else passed++;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_rr_wrap();
    test_single();
    test_hold_requeue();
    test_data_change();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
